rng_share_arb: RTL and testbench
================================

// Module: rng_share_arb
// PURPOSE
//   Shares the single RNG byte source of tt_um_rng among NUM_REQ consumers.
//   Grants one requester at a time, round-robin, and fetches exactly one byte
//   per grant over a valid/ready handshake.
//   Holds that byte until the granted consumer acks it.
//   Sits between the RNG core and the consumers (key/nonce builders, output port).
// PARAMETERS
//   NUM_REQ     4   number of requesters (>=1)
//   DATA_W      8   RNG byte width
//   RCT_CUTOFF  4   repeat count that trips the health test (RNG_RCT_EN only)
// PORTS
//   clk          in   1        clock, single domain
//   rst          in   1        synchronous, active-high reset
//   enable       in   1        permits new grants (tie to ena)
//   rng_valid    in   1        RNG byte available
//   rng_data     in   DATA_W   RNG byte
//   rng_ready    out  1        arbiter accepts rng_data this cycle
//   req          in   NUM_REQ  level request, one bit per consumer
//   gnt          out  NUM_REQ  one-hot grant, held for the whole transaction
//   ack          in   NUM_REQ  consumer has taken out_data (only gnt'd bit counts)
//   out_valid    out  1        out_data valid for granted consumer
//   out_data     out  DATA_W   delivered byte
//   busy         out  1        state != IDLE
//   health_fail  out  1        sticky RCT failure (0 without RNG_RCT_EN)
// BEHAVIOUR
//   Reset values: state=IDLE, gnt=0, out_valid=0, out_data=0, rng_ready=0,
//     busy=0, health_fail=0, rr_ptr=0, rct counters=0.
//   rst has priority over everything, including a transaction in flight.
//   rng_ready is combinational: (state==FETCH).
//   Other outputs are registered.
//   IDLE:
//     If enable && |req, winner = first set req bit searching rr_ptr, rr_ptr+1, .. wrapping mod NUM_REQ.
//     gnt <= onehot(winner); go to FETCH.
//   FETCH:
//     On rng_valid && rng_ready: out_data <= rng_data, out_valid <= 1, go to DELIVER.
//     Stalls indefinitely while rng_valid=0; gnt stays held.
//     If req[winner] drops: gnt <= 0, go to IDLE, no RNG byte consumed, rr_ptr unchanged.
//   DELIVER:
//     out_valid, out_data and gnt stay stable until ack[winner].
//     On ack[winner], or on req[winner] drop (abandon, byte discarded):
//       out_valid <= 0, gnt <= 0, rr_ptr <= (winner+1) mod NUM_REQ, go to IDLE.
//     out_data keeps its last value after release.
//   Latency: req sampled at edge t gives gnt at t+1.
//     With rng_valid already high, out_valid is high at t+2.
//     Minimum 3 cycles per byte (IDLE, FETCH, DELIVER).
//   ack bits of non-granted ports are ignored in every state.
//   enable=0 blocks only the IDLE->FETCH transition; an in-flight transaction completes.
//   NUM_REQ=1: rr_ptr is constant 0.
// CONFIGURATION
//   RNG_RCT_EN defined:
//     Repetition-count test on every captured byte.
//     Counter increments when the byte equals the previous captured byte, resets to 1 otherwise.
//     When the count reaches RCT_CUTOFF, the byte is not delivered.
//     health_fail <= 1 (sticky); go to FAULT: gnt=0, out_valid=0, rng_ready=0.
//     FAULT is left only by rst.
//   RNG_RCT_EN undefined:
//     No FAULT state, no counter, health_fail tied to 0, RCT_CUTOFF unused.
// STRUCTURE
//   rng_pkg: state enum {IDLE, FETCH, DELIVER, FAULT}, DATA_W default, RCT count width.
//   Sub-module rng_rct_check (clk, rst, strobe, data -> fail); instantiated only under RNG_RCT_EN.
//   Round-robin priority search stays inline in rng_share_arb.
// TESTING
//   1 Reset: hold rst 2 cycles mid-DELIVER -> next cycle gnt=0, out_valid=0, busy=0, health_fail=0.
//   2 Single: req=4'b0010, rng_valid=1, rng_data=8'hA5 -> gnt=0010 at t+1, out_valid=1 with A5 at t+2;
//     ack=0010 -> gnt=0, out_valid=0 next cycle.
//   3 Fairness: req=4'b1111 held, ack every delivery -> gnt sequence 0001,0010,0100,1000,0001.
//   4 Source stall: rng_valid=0 for 5 cycles in FETCH -> rng_ready=1, gnt held, out_valid=0;
//     then rng_data=8'h3C -> 3C delivered.
//   5 Abort and stray ack: drop req[2] in FETCH -> IDLE next cycle, no rng handshake;
//     ack[0] while gnt=0100 -> ignored.
//   6 RNG_RCT_EN: 8'h00 captured 4 times (RCT_CUTOFF=4) -> health_fail=1 on the 4th capture,
//     4th byte not delivered, no grants until rst.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG sharing arbiter.
// RCT_CNT_W bounds the repetition counter and must be able to hold RCT_CUTOFF.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DELIVER,
    FAULT
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int RCT_CNT_W  = 4;

endpackage

// File: rtl/rng_rct_check.sv
// Repetition-count health test on captured RNG bytes.
// fail is combinational and asserts on the strobe whose byte brings the run length to CUTOFF.
module rng_rct_check
  import rng_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CUTOFF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              fail
);

  logic [DATA_W-1:0]    prev_q, prev_d;
  logic [RCT_CNT_W-1:0] cnt_q, cnt_d;

  // prev_q starts at 0 with cnt_q=0, so a leading zero byte correctly counts as a run of 1.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (strobe) begin
      prev_d = data;
      if (data != prev_q) begin
        cnt_d = RCT_CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign fail = strobe && (cnt_d >= RCT_CNT_W'(CUTOFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rng_share_arb.sv
// Round-robin arbiter handing out one RNG byte per grant to NUM_REQ consumers.
// Defining RNG_RCT_EN adds a sticky repetition-count health test (and the RCT_CUTOFF parameter).
module rng_share_arb
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 4,
`ifdef RNG_RCT_EN
  parameter int RCT_CUTOFF = 4,
`endif
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               rng_valid,
  input  logic [DATA_W-1:0]  rng_data,
  output logic               rng_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] ack,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               health_fail
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic               rct_fail;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        win   = PTR_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          winner_d   = win;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // A completed handshake wins over a same-cycle request drop; DELIVER then abandons it.
        if (rng_valid) begin
          if (rct_fail) begin
            gnt_d   = '0;
            state_d = FAULT;
          end else begin
            out_data_d  = rng_data;
            out_valid_d = 1'b1;
            state_d     = DELIVER;
          end
        end else if (!req[winner_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      DELIVER: begin
        if (ack[winner_q] || !req[winner_q]) begin
          out_valid_d = 1'b0;
          gnt_d       = '0;
          rr_ptr_d    = PTR_W'((int'(winner_q) + 1) % NUM_REQ);
          state_d     = IDLE;
        end
      end
      FAULT: begin
        gnt_d       = '0;
        out_valid_d = 1'b0;
`ifndef RNG_RCT_EN
        state_d     = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef RNG_RCT_EN
  logic rct_strobe;
  logic health_q;

  assign rct_strobe = (state_q == FETCH) && rng_valid;

  rng_rct_check #(
    .DATA_W (DATA_W),
    .CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk    (clk),
    .rst    (rst),
    .strobe (rct_strobe),
    .data   (rng_data),
    .fail   (rct_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      health_q <= 1'b0;
    end else if (rct_fail) begin
      health_q <= 1'b1;
    end
  end

  assign health_fail = health_q;
`else
  assign rct_fail    = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign rng_ready = (state_q == FETCH);
  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rng_share_arb.sv
// Directed testbench for rng_share_arb; the health-test steps run only when RNG_RCT_EN is defined.
module tb_rng_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rng_valid;
  logic [7:0] rng_data;
  logic       rng_ready;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       health_fail;

  int n_total = 0;
  int n_pass  = 0;

  rng_share_arb dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rng_valid   (rng_valid),
    .rng_data    (rng_data),
    .rng_ready   (rng_ready),
    .req         (req),
    .gnt         (gnt),
    .ack         (ack),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] fair_seq [5];
    fair_seq[0] = 4'b0001;
    fair_seq[1] = 4'b0010;
    fair_seq[2] = 4'b0100;
    fair_seq[3] = 4'b1000;
    fair_seq[4] = 4'b0001;

    rst = 1'b1; enable = 1'b1; rng_valid = 1'b0; rng_data = 8'h00;
    req = 4'b0000; ack = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt",       32'(gnt),         32'h0);
    chk("rst_out_valid", 32'(out_valid),   32'h0);
    chk("rst_out_data",  32'(out_data),    32'h0);
    chk("rst_rng_ready", 32'(rng_ready),   32'h0);
    chk("rst_busy",      32'(busy),        32'h0);
    chk("rst_health",    32'(health_fail), 32'h0);

    // Single transaction
    req = 4'b0010; rng_valid = 1'b1; rng_data = 8'hA5;
    tick();
    chk("single_gnt",       32'(gnt),       32'h2);
    chk("single_busy",      32'(busy),      32'h1);
    chk("single_ready",     32'(rng_ready), 32'h1);
    chk("single_ov_early",  32'(out_valid), 32'h0);
    tick();
    chk("single_ov",        32'(out_valid), 32'h1);
    chk("single_data",      32'(out_data),  32'hA5);
    chk("single_ready_dlv", 32'(rng_ready), 32'h0);
    ack = 4'b0010; req = 4'b0000;
    tick();
    ack = 4'b0000;
    chk("single_rel_gnt",  32'(gnt),       32'h0);
    chk("single_rel_ov",   32'(out_valid), 32'h0);
    chk("single_rel_data", 32'(out_data),  32'hA5);
    chk("single_rel_busy", 32'(busy),      32'h0);

    // Reset in the middle of DELIVER
    req = 4'b1000; rng_data = 8'h5A;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h8);
    tick();
    chk("mid_ov", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    tick();
    chk("mid_rst_gnt",    32'(gnt),         32'h0);
    chk("mid_rst_ov",     32'(out_valid),   32'h0);
    chk("mid_rst_busy",   32'(busy),        32'h0);
    chk("mid_rst_health", 32'(health_fail), 32'h0);
    chk("mid_rst_data",   32'(out_data),    32'h0);
    rst = 1'b0; req = 4'b0000;

    // Fairness: all four requesting, each delivery acked
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rng_data = 8'h10 + 8'(k);
      tick();
      chk("fair_gnt", 32'(gnt), 32'(fair_seq[k]));
      tick();
      chk("fair_ov",   32'(out_valid), 32'h1);
      chk("fair_data", 32'(out_data),  32'h10 + 32'(k));
      ack = fair_seq[k];
      tick();
      ack = 4'b0000;
      chk("fair_rel_gnt", 32'(gnt),       32'h0);
      chk("fair_rel_ov",  32'(out_valid), 32'h0);
    end
    req = 4'b0000;

    // Source stall in FETCH
    rng_valid = 1'b0; req = 4'b0100;
    tick();
    chk("stall_gnt0", 32'(gnt), 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", 32'(rng_ready), 32'h1);
      chk("stall_gnt",   32'(gnt),       32'h4);
      chk("stall_ov",    32'(out_valid), 32'h0);
    end
    rng_valid = 1'b1; rng_data = 8'h3C;
    tick();
    rng_valid = 1'b0;
    chk("stall_ov_end",   32'(out_valid), 32'h1);
    chk("stall_data_end", 32'(out_data),  32'h3C);
    ack = 4'b0100; req = 4'b0000;
    tick();
    ack = 4'b0000;
    chk("stall_rel_gnt", 32'(gnt), 32'h0);

    // Abort in FETCH, then stray ack during DELIVER
    req = 4'b0100;
    tick();
    chk("abort_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    chk("abort_gnt_rel", 32'(gnt),       32'h0);
    chk("abort_busy",    32'(busy),      32'h0);
    chk("abort_data",    32'(out_data),  32'h3C);
    chk("abort_ov",      32'(out_valid), 32'h0);
    req = 4'b0100; rng_valid = 1'b1; rng_data = 8'h77;
    tick();
    chk("stray_gnt", 32'(gnt), 32'h4);
    tick();
    rng_valid = 1'b0;
    chk("stray_ov", 32'(out_valid), 32'h1);
    ack = 4'b0001;
    tick();
    chk("stray_gnt_held", 32'(gnt),       32'h4);
    chk("stray_ov_held",  32'(out_valid), 32'h1);
    chk("stray_data",     32'(out_data),  32'h77);
    ack = 4'b0100; req = 4'b0000;
    tick();
    ack = 4'b0000;
    chk("stray_rel_gnt", 32'(gnt), 32'h0);
    req = 4'b0101;
    tick();
    chk("rr_after_2", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    chk("rr_abort_busy", 32'(busy), 32'h0);

    // enable low blocks new grants
    enable = 1'b0; req = 4'b0010;
    tick();
    tick();
    chk("en_low_gnt",  32'(gnt),  32'h0);
    chk("en_low_busy", 32'(busy), 32'h0);
    enable = 1'b1;
    tick();
    chk("en_high_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("en_drop_busy", 32'(busy), 32'h0);

`ifdef RNG_RCT_EN
    // Health test: four identical captures trip the RCT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001; rng_valid = 1'b1; rng_data = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rct_gnt", 32'(gnt), 32'h1);
      tick();
      chk("rct_ov",     32'(out_valid),   32'h1);
      chk("rct_health", 32'(health_fail), 32'h0);
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
    end
    tick();
    chk("rct_gnt4", 32'(gnt), 32'h1);
    tick();
    chk("rct_fail",      32'(health_fail), 32'h1);
    chk("rct_fail_ov",   32'(out_valid),   32'h0);
    chk("rct_fail_gnt",  32'(gnt),         32'h0);
    chk("rct_fail_busy", 32'(busy),        32'h1);
    rng_data = 8'h42;
    tick();
    tick();
    tick();
    chk("fault_gnt",    32'(gnt),         32'h0);
    chk("fault_ready",  32'(rng_ready),   32'h0);
    chk("fault_health", 32'(health_fail), 32'h1);
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    chk("fault_rst_health", 32'(health_fail), 32'h0);
    chk("fault_rst_busy",   32'(busy),        32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
